sort_4x8b_byte_packer: RTL and testbench

- Upstream feeder for the 4x8-bit bitonic sort stage.
- Accepts a byte stream over a valid/ready handshake and packs every 4 bytes into one 32-bit word.
- Presents each word, registered, on a valid/ready output whose data bus drives the sorter's 32-bit data input directly.
- Supports early termination via in_last: a partial group is padded to a full word and flagged.

---
 rtl/sort_4x8b_byte_packer_if.sv | 31 +++
 rtl/sort_4x8b_byte_packer.sv | 124 ++++++++++++
 tb/tb_sort_4x8b_byte_packer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_4x8b_byte_packer_if.sv
// Byte-in / word-out stream bundle for the sort-stage byte packer.
//   in_valid/in_ready/in_data/in_last : upstream byte handshake
//   out_valid/out_ready               : downstream word handshake
//   out_data                          : packed word, lane k at [DATA_W*k +: DATA_W]
//   out_pad_mask                      : bit k set = lane k is padding
//   out_last                          : word was closed by in_last
// Modports: master drives bytes in and accepts words; slave is the packer itself.
interface sort_4x8b_byte_packer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W*LANES-1:0] out_data;
  logic [LANES-1:0]        out_pad_mask;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_pad_mask, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_pad_mask, out_last
  );
endinterface

// File: rtl/sort_4x8b_byte_packer.sv
// Packs a byte stream into LANES-wide words for the bitonic sort stage.
// Bytes fill lanes 0..LANES-1 in arrival order. A group closes on its last lane or on in_last;
// an early close pads the remaining lanes with PAD_VALUE and flags them in out_pad_mask.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : stream bundle (slave side), see sort_4x8b_byte_packer_if
module sort_4x8b_byte_packer #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       LANES     = 4,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  sort_4x8b_byte_packer_if.slave  bus
);

  localparam int unsigned      CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  // Lane counter and assembly buffer for all lanes except the last; the closing byte
  // bypasses the buffer and lands directly in the output register.
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [LANES-2:0][DATA_W-1:0]    asm_q, asm_d;

  logic                            out_valid_q, out_valid_d;
  logic [LANES-1:0][DATA_W-1:0]    out_data_q, out_data_d;
  logic [LANES-1:0]                out_pad_q, out_pad_d;
  logic                            out_last_q, out_last_d;

  logic                            at_last_lane;
  logic                            in_ready;
  logic                            accept;
  logic                            close;
  logic                            xfer;
  logic [LANES-1:0][DATA_W-1:0]    lanes_ext;
  logic [LANES-1:0][DATA_W-1:0]    word;
  logic [LANES-1:0]                word_pad;

  // Handshake decode. Only a closing byte needs the output register, so only it can be
  // stalled by downstream backpressure. in_last is an input, so there is no ready loop.
  always_comb begin
    at_last_lane = (cnt_q == LAST_LANE);
    in_ready     = (!at_last_lane && !bus.in_last) || !out_valid_q || bus.out_ready;
    accept       = bus.in_valid && in_ready;
    close        = accept && (at_last_lane || bus.in_last);
    xfer         = out_valid_q && bus.out_ready;
  end

  // Word being closed this cycle: buffered lanes below cnt, current byte at cnt, pad above.
  always_comb begin
    lanes_ext = {PAD_VALUE, asm_q};
    word      = '0;
    word_pad  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (k < int'(cnt_q)) begin
        word[k] = lanes_ext[k];
      end else if (k == int'(cnt_q)) begin
        word[k] = bus.in_data;
      end else begin
        word[k]     = PAD_VALUE;
        word_pad[k] = 1'b1;
      end
    end
  end

  // Next state. A close in the same cycle as a transfer reloads the register and keeps
  // out_valid high, giving one word per LANES input cycles with no bubble.
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pad_d   = out_pad_q;
    out_last_d  = out_last_q;

    if (close) begin
      cnt_d       = '0;
      asm_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_pad_d   = word_pad;
      out_last_d  = bus.in_last;
    end else begin
      if (accept) begin
        for (int k = 0; k < int'(LANES) - 1; k++) begin
          if (k == int'(cnt_q)) begin
            asm_d[k] = bus.in_data;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (xfer) begin
        // Payload holds its last value; only the valid flag drops.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pad_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pad_q   <= out_pad_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_pad_mask = out_pad_q;
  assign bus.out_last     = out_last_q;

endmodule

// File: tb/tb_sort_4x8b_byte_packer.sv
module tb_sort_4x8b_byte_packer;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 4;
  localparam logic [7:0]  PAD    = 8'h00;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sort_4x8b_byte_packer_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  sort_4x8b_byte_packer #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .PAD_VALUE(PAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted bytes gathered into groups; a full or in_last-terminated
  // group becomes one expected {last, pad_mask, word} entry.
  logic [7:0]  grp[$];
  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready)
        got_q.push_back({bus.out_last, bus.out_pad_mask, bus.out_data});
      if (bus.in_valid && bus.in_ready) begin
        logic [31:0] w;
        logic [3:0]  m;
        grp.push_back(bus.in_data);
        if (grp.size() == LANES || bus.in_last) begin
          for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = (k < grp.size()) ? grp[k] : PAD;
            m[k]        = (k >= grp.size());
          end
          exp_q.push_back({bus.in_last, m, w});
          grp.delete();
        end
      end
    end
  end

  task automatic clear_model();
    grp.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  // Present one byte until it is accepted; returns #1 after the accepting edge.
  task automatic drive_byte(input logic [7:0] d, input logic l);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %h not accepted, required acceptance within 50 cycles", d);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle_drain();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000000", bus.out_data);
    end
    checks++;
    if (bus.out_pad_mask !== 4'h0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mask_last: got %b/%b want 0000/0", bus.out_pad_mask, bus.out_last);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    clear_model();
  endtask

  task automatic test_basic();
    logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_model();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_byte(b[i], 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid);
    end
    drive_byte(b[3], 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211) begin
      errors++;
      $display("FAIL basic_word: got v=%b %h want v=1 44332211", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.out_pad_mask !== 4'h0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_mask_last: got %b/%b want 0000/0", bus.out_pad_mask, bus.out_last);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle: got v=%b want 0", bus.out_valid);
    end
    idle_drain();
  endtask

  task automatic test_stream();
    logic [31:0] w[3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    int stalls;
    clear_model();
    stalls        = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_last   = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      bus.in_data = 8'(i);
      @(negedge clk);
      if (bus.in_ready !== 1'b1) stalls++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    idle_drain();
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL stream_ready: got %0d stalled cycles want 0", stalls);
    end
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL stream_count: got %0d words want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== {1'b0, 4'h0, w[i]}) begin
          errors++; $display("FAIL stream_word%0d: got %h want %h", i, got_q[i], {1'b0, 4'h0, w[i]});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    bit stable;
    clear_model();
    bus.out_ready = 1'b1;
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b0);
    bus.out_ready = 1'b0;
    drive_byte(8'h44, 1'b0);
    for (int i = 0; i < 3; i++) drive_byte(b[i], 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = b[3];
    stable       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211)
        stable = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stall: got rdy=%b v=%b %h want rdy=0 v=1 44332211",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h88776655) begin
      errors++;
      $display("FAIL bp_next_word: got v=%b %h want v=1 88776655", bus.out_valid, bus.out_data);
    end
    idle_drain();
    checks++;
    if (got_q.size() != 2 || got_q[0][31:0] !== 32'h44332211 || got_q[1][31:0] !== 32'h88776655)
    begin
      errors++; $display("FAIL bp_order: got %0d words want 44332211 then 88776655", got_q.size());
    end
  endtask

  task automatic test_last_partial();
    clear_model();
    bus.out_ready = 1'b0;
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_pad_mask, bus.out_data} !==
        {1'b1, 1'b1, 4'b1100, 32'h0000BBAA}) begin
      errors++;
      $display("FAIL partial_word: got v=%b l=%b m=%b %h want v=1 l=1 m=1100 0000bbaa",
               bus.out_valid, bus.out_last, bus.out_pad_mask, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) drive_byte(8'(i), 1'b0);
    checks++;
    if ({bus.out_last, bus.out_pad_mask, bus.out_data} !== {1'b0, 4'b0000, 32'h04030201}) begin
      errors++;
      $display("FAIL partial_next_group: got l=%b m=%b %h want l=0 m=0000 04030201",
               bus.out_last, bus.out_pad_mask, bus.out_data);
    end
    idle_drain();
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    drive_byte(8'hE1, 1'b0);
    drive_byte(8'hE2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_pad_mask, bus.out_data} !== 38'h0) begin
      errors++;
      $display("FAIL midreset_clear: got v=%b l=%b m=%b %h want all zero",
               bus.out_valid, bus.out_last, bus.out_pad_mask, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    for (int i = 1; i <= 4; i++) drive_byte(8'(i), 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_pad_mask, bus.out_data} !== {1'b1, 4'b0000, 32'h04030201}) begin
      errors++;
      $display("FAIL midreset_fresh: got v=%b m=%b %h want v=1 m=0000 04030201",
               bus.out_valid, bus.out_pad_mask, bus.out_data);
    end
    idle_drain();
  endtask

  task automatic test_single_last();
    bus.out_ready = 1'b1;
    drive_byte(8'h7F, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_pad_mask, bus.out_data} !==
        {1'b1, 1'b1, 4'b1110, 32'h0000007F}) begin
      errors++;
      $display("FAIL single_last: got v=%b l=%b m=%b %h want v=1 l=1 m=1110 0000007f",
               bus.out_valid, bus.out_last, bus.out_pad_mask, bus.out_data);
    end
    idle_drain();
  endtask

  task automatic test_random();
    clear_model();
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.in_last   = ($urandom_range(0, 5) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    // Finish any open group so every accepted byte reaches the output.
    drive_byte(8'h5A, 1'b1);
    idle_drain();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
      errors++;
      $display("FAIL random_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end else begin
      int bad;
      bad = 0;
      foreach (got_q[i]) begin
        if (got_q[i] !== exp_q[i]) begin
          if (bad == 0)
            $display("FAIL random_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
          bad++;
        end
      end
      checks++;
      if (bad != 0) errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_last_partial();
    test_mid_reset();
    test_single_last();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
